peripheral_noc_demux_buffered: RTL and testbench

Class-based NoC packet demultiplexer with a configurable header class field, per-channel registered output buffering and packet-atomic routing. Sits between a NoC network adapter ingress port and up to eight peripheral flit sinks. Each output channel is decoupled by a two-entry skid buffer, so one stalled sink never creates combinational paths to the other sinks. Unmapped classes go to a fallback channel or are dropped, depending on configuration.

---
 rtl/peripheral_noc_demux_pkg.sv | 26 ++
 rtl/peripheral_noc_demux_skid.sv | 84 ++++++++
 rtl/peripheral_noc_demux_buffered.sv | 162 ++++++++++++++++
 tb/tb_peripheral_noc_demux_buffered.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_noc_demux_pkg.sv
// Shared types and helpers for the class-based NoC packet demultiplexer.
// The DROP state only exists when PERIPHERAL_NOC_DEMUX_DROP_EN is defined.
package peripheral_noc_demux_pkg;

`ifdef PERIPHERAL_NOC_DEMUX_DROP_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } demux_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1
    } demux_state_t;
`endif

    localparam int CLASS_LSB_DEFAULT   = 24;
    localparam int CLASS_WIDTH_DEFAULT = 3;

    // Keep only the lowest set bit so a multi-bit mapping entry picks one channel.
    function automatic logic [7:0] onehot_lowest(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/peripheral_noc_demux_skid.sv
// Two-entry flit+last buffer; outputs always come straight from the head registers.
// Full is derived from registered occupancy only, so a push is never accepted into a full buffer.
module peripheral_noc_demux_skid #(
    parameter int FLIT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    input  logic [FLIT_WIDTH-1:0] push_flit,
    input  logic                  push_last,
    output logic                  full,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [1:0]            count_q, count_d;
    logic [FLIT_WIDTH-1:0] head_flit_q, head_flit_d;
    logic [FLIT_WIDTH-1:0] tail_flit_q, tail_flit_d;
    logic                  head_last_q, head_last_d;
    logic                  tail_last_q, tail_last_d;
    logic                  pop;

    assign full      = (count_q == 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_flit  = head_flit_q;
    assign out_last  = head_last_q;

    always_comb begin
        pop         = (count_q != 2'd0) && out_ready;
        count_d     = count_q;
        head_flit_d = head_flit_q;
        head_last_d = head_last_q;
        tail_flit_d = tail_flit_q;
        tail_last_d = tail_last_q;
        case (count_q)
            2'd0: begin
                if (push_valid) begin
                    head_flit_d = push_flit;
                    head_last_d = push_last;
                    count_d     = 2'd1;
                end
            end
            2'd1: begin
                if (push_valid && pop) begin
                    head_flit_d = push_flit;
                    head_last_d = push_last;
                end else if (push_valid) begin
                    tail_flit_d = push_flit;
                    tail_last_d = push_last;
                    count_d     = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_flit_d = tail_flit_q;
                    head_last_d = tail_last_q;
                    count_d     = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= 2'd0;
            head_flit_q <= '0;
            head_last_q <= 1'b0;
            tail_flit_q <= '0;
            tail_last_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            head_flit_q <= head_flit_d;
            head_last_q <= head_last_d;
            tail_flit_q <= tail_flit_d;
            tail_last_q <= tail_last_d;
        end
    end

endmodule

// File: rtl/peripheral_noc_demux_buffered.sv
// Class-based packet demux: header class selects one output channel, each behind a two-entry skid.
// Define PERIPHERAL_NOC_DEMUX_DROP_EN to discard unmapped-class packets instead of sending them to channel 0.
module peripheral_noc_demux_buffered
    import peripheral_noc_demux_pkg::*;
#(
    parameter int          FLIT_WIDTH     = 32,
    parameter int          CHANNELS       = 7,
    parameter int          CLASS_LSB      = CLASS_LSB_DEFAULT,
    parameter int          CLASS_WIDTH    = CLASS_WIDTH_DEFAULT,
    parameter logic [63:0] MAPPING        = 64'h0,
    parameter int          DROP_CNT_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [FLIT_WIDTH-1:0]              in_flit,
    input  logic                               in_last,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [CHANNELS-1:0][FLIT_WIDTH-1:0] out_flit,
    output logic [CHANNELS-1:0]                out_last,
    output logic [CHANNELS-1:0]                out_valid,
    input  logic [CHANNELS-1:0]                out_ready,
    output logic [DROP_CNT_WIDTH-1:0]          drop_count
);

    localparam logic [7:0] CH_MASK = 8'((9'd1 << CHANNELS) - 9'd1);

    demux_state_t        state_q, state_d;
    logic [2:0]          sel_q, sel_d;
    logic [2:0]          hdr_class;
    logic [7:0]          map_entry;
    logic [7:0]          map_onehot;
    logic [2:0]          map_idx;
    logic                hdr_mapped;
    logic [CHANNELS-1:0] sel_onehot;
    logic [CHANNELS-1:0] tgt_onehot;
    logic                route;
    logic                hs;
    logic [CHANNELS-1:0] skid_full;
    logic [CHANNELS-1:0] push;

    always_comb begin
        hdr_class = '0;
        hdr_class[CLASS_WIDTH-1:0] = in_flit[CLASS_LSB +: CLASS_WIDTH];
        map_entry  = MAPPING[{hdr_class, 3'b000} +: 8] & CH_MASK;
        map_onehot = onehot_lowest(map_entry);
        hdr_mapped = |map_entry;
        map_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (map_onehot[i]) map_idx = 3'(i);
        end
        sel_onehot = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_onehot[i] = (sel_q == 3'(i));
        end
    end

    // Only the IDLE header decode reaches in_ready combinationally; skid fullness is registered.
    always_comb begin
        tgt_onehot = '0;
        route      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hdr_mapped) begin
                    tgt_onehot = map_onehot[CHANNELS-1:0];
                    route      = 1'b1;
                end
`ifndef PERIPHERAL_NOC_DEMUX_DROP_EN
                else begin
                    tgt_onehot[0] = 1'b1;
                    route         = 1'b1;
                end
`endif
            end
            ST_FWD: begin
                tgt_onehot = sel_onehot;
                route      = 1'b1;
            end
            default: ;
        endcase
        in_ready = route ? ~|(tgt_onehot & skid_full) : 1'b1;
        hs       = in_valid && in_ready;
        push     = tgt_onehot & {CHANNELS{hs && route}};
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (hs && !in_last) begin
                    if (route) begin
                        state_d = ST_FWD;
                        sel_d   = map_idx;
                    end
`ifdef PERIPHERAL_NOC_DEMUX_DROP_EN
                    else begin
                        state_d = ST_DROP;
                    end
`endif
                end
            end
            ST_FWD: begin
                if (hs && in_last) state_d = ST_IDLE;
            end
`ifdef PERIPHERAL_NOC_DEMUX_DROP_EN
            ST_DROP: begin
                if (hs && in_last) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sel_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

`ifdef PERIPHERAL_NOC_DEMUX_DROP_EN
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (state_q == ST_IDLE && hs && !route && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_cnt_q <= '0;
        else      drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_skid
        peripheral_noc_demux_skid #(
            .FLIT_WIDTH(FLIT_WIDTH)
        ) u_skid (
            .clk       (clk),
            .rst       (rst),
            .push_valid(push[g]),
            .push_flit (in_flit),
            .push_last (in_last),
            .full      (skid_full[g]),
            .out_flit  (out_flit[g]),
            .out_last  (out_last[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g])
        );
    end

endmodule

// File: tb/tb_peripheral_noc_demux_buffered.sv
// Directed bench for peripheral_noc_demux_buffered: CHANNELS=3, MAPPING class0->ch1, class1->ch2.
// Expectations follow PERIPHERAL_NOC_DEMUX_DROP_EN when it is defined for the build.
module tb_peripheral_noc_demux_buffered;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       in_flit;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [2:0][31:0]  out_flit;
    logic [2:0]        out_last;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;
    logic [1:0]        drop_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    peripheral_noc_demux_buffered #(
        .FLIT_WIDTH    (32),
        .CHANNELS      (3),
        .CLASS_LSB     (24),
        .CLASS_WIDTH   (3),
        .MAPPING       (64'h0000_0000_0000_0402),
        .DROP_CNT_WIDTH(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_count(drop_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++;
        if (out_valid !== 3'b000) begin bad++; $display("FAIL reset_valid got=%b want=000", out_valid); end
        total++;
        if (out_flit !== 96'h0) begin bad++; $display("FAIL reset_flit got=%h want=0", out_flit); end
        total++;
        if (out_last !== 3'b000) begin bad++; $display("FAIL reset_last got=%b want=000", out_last); end
        total++;
        if (drop_count !== 2'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_count); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] f [4] = '{32'h0000_0000, 32'h0500_0011, 32'h0100_0022, 32'h0000_0033};
        out_ready = 3'b111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_flit = f[i]; in_last = (i == 3);
            #1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready[%0d] got=%b want=1", i, in_ready); end
            tick();
            total++;
            if (out_valid !== 3'b010) begin bad++; $display("FAIL basic_valid[%0d] got=%b want=010", i, out_valid); end
            total++;
            if (out_flit[1] !== f[i]) begin bad++; $display("FAIL basic_flit[%0d] got=%h want=%h", i, out_flit[1], f[i]); end
            total++;
            if (out_last[1] !== (i == 3)) begin bad++; $display("FAIL basic_last[%0d] got=%b want=%b", i, out_last[1], (i == 3)); end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 3'b000) begin bad++; $display("FAIL basic_drain got=%b want=000", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] pk [5] = '{32'h0000_0100, 32'h0700_0101, 32'h0000_0102, 32'h0000_0103, 32'h0000_0104};
        int tx = 0;
        int rx = 0;
        bit seen_stall = 1'b0;
        out_ready = 3'b101;
        for (int cyc = 0; cyc < 40 && rx < 5; cyc++) begin
            if (cyc == 8) out_ready = 3'b111;
            if (tx < 5) begin
                in_valid = 1'b1; in_flit = pk[tx]; in_last = (tx == 4);
            end else begin
                in_valid = 1'b0; in_flit = 32'h0; in_last = 1'b0;
            end
            #1;
            total++;
            if ((out_valid & 3'b101) !== 3'b000) begin bad++; $display("FAIL bp_other_ch cyc=%0d got=%b want=000", cyc, out_valid & 3'b101); end
            if (cyc < 8 && !in_ready && !seen_stall) begin
                seen_stall = 1'b1;
                total++;
                if (tx != 2) begin bad++; $display("FAIL bp_stall_after got=%0d want=2", tx); end
            end
            if (cyc == 5) begin
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_held_ready got=%b want=0", in_ready); end
                total++;
                if (out_valid[1] !== 1'b1 || out_flit[1] !== pk[0]) begin
                    bad++; $display("FAIL bp_held_head got=%b/%h want=1/%h", out_valid[1], out_flit[1], pk[0]);
                end
            end
            if (out_valid[1] && out_ready[1]) begin
                total++;
                if (out_flit[1] !== pk[rx] || out_last[1] !== (rx == 4)) begin
                    bad++; $display("FAIL bp_order[%0d] got=%h/%b want=%h/%b", rx, out_flit[1], out_last[1], pk[rx], (rx == 4));
                end
                rx++;
            end
            if (in_valid && in_ready) tx++;
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (!seen_stall) begin bad++; $display("FAIL bp_no_stall got=0 want=1"); end
        total++;
        if (rx != 5) begin bad++; $display("FAIL bp_delivered got=%0d want=5", rx); end
    endtask

    task automatic test_back_to_back();
        out_ready = 3'b111;
        in_valid = 1'b1; in_flit = 32'h0100_0000; in_last = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_single_ready got=%b want=1", in_ready); end
        tick();
        in_flit = 32'h0000_00A0; in_last = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_no_gap got=%b want=1", in_ready); end
        total++;
        if (out_valid !== 3'b100 || out_flit[2] !== 32'h0100_0000 || out_last[2] !== 1'b1) begin
            bad++; $display("FAIL b2b_ch2 got=%b/%h/%b want=100/01000000/1", out_valid, out_flit[2], out_last[2]);
        end
        tick();
        in_flit = 32'h0000_00A1; in_last = 1'b1;
        #1;
        total++;
        if (out_valid !== 3'b010 || out_flit[1] !== 32'h0000_00A0) begin
            bad++; $display("FAIL b2b_q0 got=%b/%h want=010/000000a0", out_valid, out_flit[1]);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 3'b010 || out_flit[1] !== 32'h0000_00A1 || out_last[1] !== 1'b1) begin
            bad++; $display("FAIL b2b_q1 got=%b/%h/%b want=010/000000a1/1", out_valid, out_flit[1], out_last[1]);
        end
        tick();
        total++;
        if (out_valid !== 3'b000) begin bad++; $display("FAIL b2b_drain got=%b want=000", out_valid); end
    endtask

    task automatic test_unmapped();
        logic [31:0] u [4] = '{32'h0500_0001, 32'h0000_0002, 32'h0300_0003, 32'h0500_0004};
        out_ready = 3'b111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_flit = u[i]; in_last = (i == 3);
            #1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL unm_in_ready[%0d] got=%b want=1", i, in_ready); end
            tick();
`ifdef PERIPHERAL_NOC_DEMUX_DROP_EN
            total++;
            if (out_valid !== 3'b000) begin bad++; $display("FAIL unm_drop_valid[%0d] got=%b want=000", i, out_valid); end
            total++;
            if (drop_count !== 2'd1) begin bad++; $display("FAIL unm_drop_count[%0d] got=%0d want=1", i, drop_count); end
`else
            total++;
            if (out_valid !== 3'b001 || out_flit[0] !== u[i] || out_last[0] !== (i == 3)) begin
                bad++; $display("FAIL unm_ch0[%0d] got=%b/%h/%b want=001/%h/%b", i, out_valid, out_flit[0], out_last[0], u[i], (i == 3));
            end
            total++;
            if (drop_count !== 2'd0) begin bad++; $display("FAIL unm_drop_count[%0d] got=%0d want=0", i, drop_count); end
`endif
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 3'b000) begin bad++; $display("FAIL unm_drain got=%b want=000", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 3'b000;
        in_valid = 1'b1; in_flit = 32'h0000_0200; in_last = 1'b0;
        tick();
        in_flit = 32'h0000_0201;
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 3'b010 || in_ready !== 1'b0) begin
            bad++; $display("FAIL rmid_pre got=%b/%b want=010/0", out_valid, in_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 3'b000) begin bad++; $display("FAIL rmid_async_valid got=%b want=000", out_valid); end
        total++;
        if (out_flit !== 96'h0 || out_last !== 3'b000) begin bad++; $display("FAIL rmid_async_data got=%h/%b want=0/000", out_flit, out_last); end
        total++;
        if (drop_count !== 2'd0) begin bad++; $display("FAIL rmid_drop got=%0d want=0", drop_count); end
        tick();
        tick();
        rst = 1'b1;
        out_ready = 3'b111;
        in_valid = 1'b1; in_flit = 32'h0100_0077; in_last = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_hdr_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 3'b100 || out_flit[2] !== 32'h0100_0077) begin
            bad++; $display("FAIL rmid_hdr_route got=%b/%h want=100/01000077", out_valid, out_flit[2]);
        end
        tick();
        total++;
        if (out_valid !== 3'b000) begin bad++; $display("FAIL rmid_drain got=%b want=000", out_valid); end
    endtask

    task automatic test_drop_sat();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        out_ready = 3'b111;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_flit = 32'h0500_0000 + 32'(i); in_last = 1'b1;
            #1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL sat_in_ready[%0d] got=%b want=1", i, in_ready); end
            tick();
`ifdef PERIPHERAL_NOC_DEMUX_DROP_EN
            total++;
            if (drop_count !== exp_cnt[i]) begin bad++; $display("FAIL sat_count[%0d] got=%0d want=%0d", i, drop_count, exp_cnt[i]); end
            total++;
            if (out_valid !== 3'b000) begin bad++; $display("FAIL sat_valid[%0d] got=%b want=000", i, out_valid); end
`else
            total++;
            if (drop_count !== 2'd0) begin bad++; $display("FAIL sat_count[%0d] got=%0d want=0 (cfg %0d)", i, drop_count, exp_cnt[i]); end
            total++;
            if (out_valid !== 3'b001 || out_flit[0] !== 32'h0500_0000 + 32'(i)) begin
                bad++; $display("FAIL sat_ch0[%0d] got=%b/%h want=001/%h", i, out_valid, out_flit[0], 32'h0500_0000 + 32'(i));
            end
`endif
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        in_flit = 32'h0;
        in_last = 1'b0;
        in_valid = 1'b0;
        out_ready = 3'b000;
        #3;
        test_reset();
        tick();
        rst = 1'b1;
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_unmapped();
        test_reset_mid();
        test_drop_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
